// File: rtl/mrr_pathway_merge_pkg.sv
// Shared constants and state encoding for the pathway merge stage.
package mrr_pathway_merge_pkg;

  localparam logic [7:0]  MERGE_HDR_MAGIC = 8'hA5;
  localparam logic [31:0] MERGE_TERM_WORD = 32'hDEAD_0000;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PASS,
    TERM,
    DRAIN
  } merge_state_e;

endpackage

// File: rtl/mrr_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module mrr_rr_arbiter #(
  parameter int NUM_PATHWAYS      = 4,
  parameter int PATHWAY_IDX_WIDTH = 2
) (
  input  logic [NUM_PATHWAYS-1:0]      req,
  input  logic [PATHWAY_IDX_WIDTH-1:0] ptr,
  output logic [PATHWAY_IDX_WIDTH-1:0] grant_idx,
  output logic                         grant_vld
);

  int cand;

  // Scan from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int i = NUM_PATHWAYS - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_PATHWAYS) cand = cand - NUM_PATHWAYS;
      if (req[PATHWAY_IDX_WIDTH'(cand)]) begin
        grant_idx = PATHWAY_IDX_WIDTH'(cand);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mrr_pathway_merge.sv
// Packet-atomic round-robin merge of decoded pathway lanes into one host stream,
// with a per-packet header word and a mid-packet stall watchdog.
module mrr_pathway_merge
  import mrr_pathway_merge_pkg::*;
#(
  parameter int          NUM_PATHWAYS      = 4,
  parameter int          PATHWAY_IDX_WIDTH = 2,
  parameter int          TIMEOUT_WIDTH     = 16,
  parameter logic [7:0]  HDR_MAGIC         = MERGE_HDR_MAGIC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [32*NUM_PATHWAYS-1:0]   i_tdata,
  input  logic [NUM_PATHWAYS-1:0]      i_tkeep,
  input  logic [NUM_PATHWAYS-1:0]      i_tlast,
  input  logic [NUM_PATHWAYS-1:0]      i_tvalid,
  output logic [NUM_PATHWAYS-1:0]      i_tready,
  output logic [31:0]                  o_tdata,
  output logic                         o_tkeep,
  output logic                         o_tlast,
  output logic                         o_tvalid,
  input  logic                         o_tready,
  input  logic [NUM_PATHWAYS-1:0]      enable_mask,
  input  logic [TIMEOUT_WIDTH-1:0]     stall_timeout,
  output logic [31:0]                  pkt_count,
  output logic [15:0]                  drop_count,
  output logic [PATHWAY_IDX_WIDTH-1:0] active_pathway
);

  merge_state_e                 state, state_nxt;
  logic [PATHWAY_IDX_WIDTH-1:0] grant, rr, arb_idx, next_rr;
  logic                         arb_vld;
  logic [15:0]                  seq;
  logic [TIMEOUT_WIDTH-1:0]     wd;
  logic [TIMEOUT_WIDTH:0]       wd_inc;
  logic                         load, xfer, wd_expire;
  logic                         g_valid, g_keep, g_last;
  logic [31:0]                  g_data;
  logic [31:0]                  lane_data [NUM_PATHWAYS];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  for (genvar k = 0; k < NUM_PATHWAYS; k++) begin : g_lane
    assign lane_data[k] = i_tdata[32*k +: 32];
  end

  assign g_valid        = i_tvalid[grant];
  assign g_keep         = i_tkeep[grant];
  assign g_last         = i_tlast[grant];
  assign g_data         = lane_data[grant];
  assign active_pathway = grant;
  assign load           = !o_tvalid || o_tready;
  assign next_rr        = (grant == PATHWAY_IDX_WIDTH'(NUM_PATHWAYS - 1)) ? '0 : grant + 1'b1;

  mrr_rr_arbiter #(
    .NUM_PATHWAYS      (NUM_PATHWAYS),
    .PATHWAY_IDX_WIDTH (PATHWAY_IDX_WIDTH)
  ) u_arb (
    .req       (i_tvalid & enable_mask),
    .ptr       (rr),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // DRAIN discards words, so it ignores output back-pressure.
  always_comb begin
    i_tready = '0;
    if ((state == PASS && load) || state == DRAIN) i_tready[grant] = 1'b1;
  end

  assign xfer      = g_valid && i_tready[grant];
  assign wd_inc    = {1'b0, wd} + 1'b1;
  assign wd_expire = (state == PASS) && (stall_timeout != '0) && load && !g_valid &&
                     (wd_inc >= {1'b0, stall_timeout});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_vld) state_nxt = HDR;
      HDR:     if (load) state_nxt = PASS;
      PASS: begin
        if (xfer && g_last) state_nxt = IDLE;
        else if (wd_expire) state_nxt = TERM;
      end
      TERM:    if (load) state_nxt = DRAIN;
      DRAIN:   if (xfer && g_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      rr         <= '0;
      seq        <= '0;
      wd         <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (arb_vld) grant <= arb_idx;
        HDR: begin
          if (load) begin
            seq <= seq + 16'd1;
            wd  <= '0;
          end
        end
        PASS: begin
          if (xfer) begin
            wd <= '0;
            if (g_last) begin
              pkt_count <= pkt_count + 32'd1;
              rr        <= next_rr;
            end
          end else if (load && !g_valid) begin
            wd <= wd_inc[TIMEOUT_WIDTH-1:0];
          end
        end
        TERM:  if (load) drop_count <= sat_inc16(drop_count);
        DRAIN: if (xfer && g_last) rr <= next_rr;
        default: ;
      endcase
    end
  end

  // Single output register stage; holds while the host back-pressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tkeep  <= 1'b0;
      o_tlast  <= 1'b0;
    end else if (load) begin
      o_tvalid <= 1'b0;
      case (state)
        HDR: begin
          o_tvalid <= 1'b1;
          o_tdata  <= {HDR_MAGIC, 8'(grant), seq};
          o_tkeep  <= 1'b1;
          o_tlast  <= 1'b0;
        end
        PASS: begin
          if (xfer) begin
            o_tvalid <= 1'b1;
            o_tdata  <= g_data;
            o_tkeep  <= g_keep;
            o_tlast  <= g_last;
          end
        end
        TERM: begin
          o_tvalid <= 1'b1;
          o_tdata  <= MERGE_TERM_WORD | 32'(grant);
          o_tkeep  <= 1'b0;
          o_tlast  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mrr_pathway_merge.sv
// Directed scoreboard bench for mrr_pathway_merge: lane queues drive stimulus,
// a forked monitor pops expected beats whenever the merged output transfers.
`timescale 1ns/1ps
module tb_mrr_pathway_merge;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] i_tdata;
  logic [N-1:0]    i_tkeep, i_tlast, i_tvalid, i_tready;
  logic [31:0]     o_tdata;
  logic            o_tkeep, o_tlast, o_tvalid, o_tready;
  logic [N-1:0]    enable_mask;
  logic [15:0]     stall_timeout;
  logic [31:0]     pkt_count;
  logic [15:0]     drop_count;
  logic [1:0]      active_pathway;

  typedef struct packed {
    logic        idle;
    logic        last;
    logic        keep;
    logic [31:0] data;
  } lane_word_t;

  lane_word_t  lane_q[N][$];
  logic [33:0] exp_q[$];
  logic [N-1:0] will;
  int checks;
  int errors;
  bit bp_mode;

  always #5 clk = ~clk;

  mrr_pathway_merge dut (
    .clk            (clk),
    .rst            (rst),
    .i_tdata        (i_tdata),
    .i_tkeep        (i_tkeep),
    .i_tlast        (i_tlast),
    .i_tvalid       (i_tvalid),
    .i_tready       (i_tready),
    .o_tdata        (o_tdata),
    .o_tkeep        (o_tkeep),
    .o_tlast        (o_tlast),
    .o_tvalid       (o_tvalid),
    .o_tready       (o_tready),
    .enable_mask    (enable_mask),
    .stall_timeout  (stall_timeout),
    .pkt_count      (pkt_count),
    .drop_count     (drop_count),
    .active_pathway (active_pathway)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic lw(input int k, input logic [31:0] d, input logic last);
    lane_word_t w;
    w = '{idle: 1'b0, last: last, keep: 1'b1, data: d};
    lane_q[k].push_back(w);
  endtask

  task automatic li(input int k, input int n);
    lane_word_t w;
    w = '{idle: 1'b1, last: 1'b0, keep: 1'b0, data: 32'h0};
    repeat (n) lane_q[k].push_back(w);
  endtask

  task automatic ex(input logic [31:0] d, input logic keep, input logic last);
    exp_q.push_back({last, keep, d});
  endtask

  task automatic step();
    lane_word_t w;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (will[k]) void'(lane_q[k].pop_front());
      if (lane_q[k].size() > 0) begin
        w = lane_q[k][0];
        i_tvalid[k]          = !w.idle;
        i_tlast[k]           = w.last;
        i_tkeep[k]           = w.keep;
        i_tdata[32*k +: 32]  = w.data;
      end else begin
        i_tvalid[k] = 1'b0;
        i_tlast[k]  = 1'b0;
        i_tkeep[k]  = 1'b0;
      end
    end
    o_tready = bp_mode ? ~o_tready : 1'b1;
    #1;
    for (int k = 0; k < N; k++)
      will[k] = (lane_q[k].size() > 0) && (lane_q[k][0].idle || (i_tvalid[k] && i_tready[k]));
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) lane_q[k].delete();
    exp_q.delete();
    will     = '0;
    i_tvalid = '0;
    i_tlast  = '0;
    i_tkeep  = '0;
    i_tdata  = '0;
    bp_mode  = 1'b0;
    o_tready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_done(input logic [N-1:0] lanes, input int budget);
    int n;
    bit busy;
    n = 0;
    do begin
      step();
      n++;
      busy = (exp_q.size() != 0);
      for (int k = 0; k < N; k++) if (lanes[k] && lane_q[k].size() != 0) busy = 1'b1;
    end while (busy && n < budget);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats still pending after %0d cycles, required 0", exp_q.size(), n);
    end
    repeat (2) step();
  endtask

  task automatic monitor();
    logic [33:0] got, e, held_v;
    bit held;
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
        continue;
      end
      got = {o_tlast, o_tkeep, o_tdata};
      if (held) begin
        checks++;
        if (!o_tvalid || got !== held_v) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b %h required valid=1 %h", o_tvalid, got, held_v);
        end
      end
      held   = o_tvalid && !o_tready;
      held_v = got;
      if (o_tvalid && o_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got last=%0b keep=%0b data=%h required no beat", got[33], got[32], got[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL beat: got last=%0b keep=%0b data=%h required last=%0b keep=%0b data=%h",
                     got[33], got[32], got[31:0], e[33], e[32], e[31:0]);
          end
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    enable_mask = '1;
    stall_timeout = '0;
    flush();
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    #1;
    chk("rst_o_tvalid", 32'(o_tvalid), 32'h0);
    chk("rst_o_tdata", o_tdata, 32'h0);
    chk("rst_i_tready", 32'(i_tready), 32'h0);
    chk("rst_pkt_count", pkt_count, 32'h0);
    chk("rst_drop_count", 32'(drop_count), 32'h0);
    chk("rst_active", 32'(active_pathway), 32'h0);
    rst = 1'b0;

    // Single lane, 3-word packet
    lw(0, 32'h11, 1'b0); lw(0, 32'h22, 1'b0); lw(0, 32'h33, 1'b1);
    ex(32'hA500_0000, 1'b1, 1'b0);
    ex(32'h11, 1'b1, 1'b0); ex(32'h22, 1'b1, 1'b0); ex(32'h33, 1'b1, 1'b1);
    run_done(4'b0001, 200);
    chk("t1_pkt_count", pkt_count, 32'd1);

    // All lanes contend with 2-word packets
    do_reset();
    for (int k = 0; k < N; k++) begin
      lw(k, 32'h100 + 32'(k), 1'b0);
      lw(k, 32'h200 + 32'(k), 1'b1);
    end
    ex(32'hA500_0000, 1'b1, 1'b0); ex(32'h100, 1'b1, 1'b0); ex(32'h200, 1'b1, 1'b1);
    ex(32'hA501_0001, 1'b1, 1'b0); ex(32'h101, 1'b1, 1'b0); ex(32'h201, 1'b1, 1'b1);
    ex(32'hA502_0002, 1'b1, 1'b0); ex(32'h102, 1'b1, 1'b0); ex(32'h202, 1'b1, 1'b1);
    ex(32'hA503_0003, 1'b1, 1'b0); ex(32'h103, 1'b1, 1'b0); ex(32'h203, 1'b1, 1'b1);
    run_done(4'b1111, 400);
    chk("t2_pkt_count", pkt_count, 32'd4);
    // Pointer wrapped to 0: lane 0 must beat lane 1
    lw(1, 32'h1A, 1'b1); lw(0, 32'h0A, 1'b1);
    ex(32'hA500_0004, 1'b1, 1'b0); ex(32'h0A, 1'b1, 1'b1);
    ex(32'hA501_0005, 1'b1, 1'b0); ex(32'h1A, 1'b1, 1'b1);
    run_done(4'b0011, 200);
    chk("t2_pkt_count_rr", pkt_count, 32'd6);

    // Output back-pressure toggling every cycle
    do_reset();
    bp_mode = 1'b1;
    for (int i = 1; i <= 4; i++) lw(3, 32'h30 + 32'(i), i == 4);
    ex(32'hA503_0000, 1'b1, 1'b0);
    ex(32'h31, 1'b1, 1'b0); ex(32'h32, 1'b1, 1'b0); ex(32'h33, 1'b1, 1'b0); ex(32'h34, 1'b1, 1'b1);
    run_done(4'b1000, 200);
    bp_mode = 1'b0;
    chk("t3_pkt_count", pkt_count, 32'd1);
    chk("t3_active", 32'(active_pathway), 32'd3);

    // Stall watchdog truncates lane 2, lane 3 follows cleanly
    do_reset();
    stall_timeout = 16'd5;
    lw(2, 32'h201, 1'b0); li(2, 5);
    lw(2, 32'h202, 1'b0); lw(2, 32'h203, 1'b0); lw(2, 32'h204, 1'b1);
    lw(3, 32'h301, 1'b1);
    ex(32'hA502_0000, 1'b1, 1'b0); ex(32'h201, 1'b1, 1'b0);
    ex(32'hDEAD_0002, 1'b0, 1'b1);
    ex(32'hA503_0001, 1'b1, 1'b0); ex(32'h301, 1'b1, 1'b1);
    run_done(4'b1100, 300);
    chk("t4_drop_count", 32'(drop_count), 32'd1);
    chk("t4_pkt_count", pkt_count, 32'd1);
    stall_timeout = 16'd0;

    // Enable mask 0101: lanes 0 and 2 alternate
    do_reset();
    enable_mask = 4'b0101;
    lw(0, 32'h0A1, 1'b1); lw(0, 32'h0A2, 1'b1);
    lw(2, 32'h2A1, 1'b1); lw(2, 32'h2A2, 1'b1);
    lw(1, 32'h1A1, 1'b1); lw(3, 32'h3A1, 1'b1);
    ex(32'hA500_0000, 1'b1, 1'b0); ex(32'h0A1, 1'b1, 1'b1);
    ex(32'hA502_0001, 1'b1, 1'b0); ex(32'h2A1, 1'b1, 1'b1);
    ex(32'hA500_0002, 1'b1, 1'b0); ex(32'h0A2, 1'b1, 1'b1);
    ex(32'hA502_0003, 1'b1, 1'b0); ex(32'h2A2, 1'b1, 1'b1);
    run_done(4'b0101, 300);
    chk("t5_pkt_count", pkt_count, 32'd4);
    // Mask bit 0 cleared while lane 0 is mid-packet
    lw(0, 32'h0B1, 1'b0); li(0, 3); lw(0, 32'h0B2, 1'b0); lw(0, 32'h0B3, 1'b1);
    lw(2, 32'h2B1, 1'b1);
    ex(32'hA500_0004, 1'b1, 1'b0);
    ex(32'h0B1, 1'b1, 1'b0); ex(32'h0B2, 1'b1, 1'b0); ex(32'h0B3, 1'b1, 1'b1);
    ex(32'hA502_0005, 1'b1, 1'b0); ex(32'h2B1, 1'b1, 1'b1);
    repeat (4) step();
    enable_mask = 4'b0100;
    run_done(4'b0101, 300);
    chk("t5_pkt_count_mask", pkt_count, 32'd6);

    // Single-word packet, then reset in the middle of a packet
    do_reset();
    enable_mask = 4'b1111;
    lw(0, 32'h5, 1'b1);
    ex(32'hA500_0000, 1'b1, 1'b0); ex(32'h5, 1'b1, 1'b1);
    run_done(4'b0001, 100);
    chk("t6_single_pkt", pkt_count, 32'd1);
    lw(1, 32'h61, 1'b0); li(1, 6); lw(1, 32'h62, 1'b1);
    ex(32'hA501_0001, 1'b1, 1'b0); ex(32'h61, 1'b1, 1'b0);
    repeat (5) step();
    chk("t6_active_before_rst", 32'(active_pathway), 32'd1);
    chk("t6_pending_before_rst", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_o_tvalid", 32'(o_tvalid), 32'h0);
    chk("t6_rst_o_tdata", o_tdata, 32'h0);
    chk("t6_rst_o_tlast", 32'({o_tlast, o_tkeep}), 32'h0);
    chk("t6_rst_i_tready", 32'(i_tready), 32'h0);
    chk("t6_rst_pkt_count", pkt_count, 32'h0);
    chk("t6_rst_active", 32'(active_pathway), 32'h0);
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lw(1, 32'h71, 1'b1);
    ex(32'hA501_0000, 1'b1, 1'b0); ex(32'h71, 1'b1, 1'b1);
    run_done(4'b0010, 100);
    chk("t6_pkt_after_rst", pkt_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
